vga_layer_compositor: RTL and testbench
=======================================

// Module: vga_layer_compositor
// PURPOSE
//  Parametrised N-layer pixel compositor replacing the fixed serial layer chain of the game top.
//  - Each drawing layer supplies an RGB value and an opaque flag for the current pixel.
//  - Picks the highest-priority enabled opaque layer and applies a display mode (normal/dim/flash/black).
//  - Delays timing signals to match the pipeline.
//  - Layer enables and mode are frame-synchronous, so screen changes never tear mid-frame.
// PARAMETERS
//  N_LAYERS     7       number of layers; index N_LAYERS-1 has highest priority (overlay)
//  RGB_W        12      pixel width, 3 equal channels of RGB_W/3 bits ({r,g,b}, r in MSBs)
//  BG_COLOR     12'h000 colour when no enabled opaque layer covers the pixel
//  FLASH_FRAMES 30      frames per flash half-period, >=1
// PORTS
//  clk              in  1            pixel clock (40 MHz)
//  rst              in  1            asynchronous, active-high reset
//  hcount_in        in  11           horizontal pixel counter from timing generator
//  vcount_in        in  11           vertical line counter
//  hsync_in         in  1            horizontal sync
//  vsync_in         in  1            vertical sync
//  hblnk_in         in  1            horizontal blanking
//  vblnk_in         in  1            vertical blanking
//  layer_rgb_in     in  N_LAYERS*RGB_W  layer i colour at bits [i*RGB_W +: RGB_W]
//  layer_opaque_in  in  N_LAYERS     1 = layer i draws this pixel
//  layer_en_in      in  N_LAYERS     requested layer enables (from FSM)
//  mode_in          in  2            00 normal, 01 dim, 10 flash, 11 black
//  hcount_out       out 11           hcount_in delayed 2 cycles
//  vcount_out       out 11           vcount_in delayed 2 cycles
//  hsync_out        out 1            hsync_in delayed 2 cycles
//  vsync_out        out 1            vsync_in delayed 2 cycles
//  hblnk_out        out 1            hblnk_in delayed 2 cycles
//  vblnk_out        out 1            vblnk_in delayed 2 cycles
//  rgb_out          out RGB_W        composited pixel
//  frame_start      out 1            1-cycle pulse on each vsync_in rising edge
// BEHAVIOUR
//  Reset
//   - All outputs 0.
//   - Shadow enables 0, shadow mode 00, frame counter 0, flash phase 0.
//   - Reset mid-frame takes effect immediately. After release, output is BG_COLOR until the next vsync rise.
//  Frame sync
//   - vsync rising edge = vsync_in high while its registered copy is low.
//   - On that cycle: load shadow_en <= layer_en_in and shadow_mode <= mode_in.
//   - frame_start goes high the next cycle, for exactly 1 cycle.
//   - Mid-frame changes to layer_en_in or mode_in have no effect until the next vsync rise.
//  Frame counter
//   - Counts vsync rises 0..FLASH_FRAMES-1, then wraps to 0 and toggles flash phase.
//   - Runs in every mode.
//  Stage 1 (registered)
//   - sel = highest i with shadow_en[i] & layer_opaque_in[i].
//   - If sel exists: pixel = layer i rgb, else BG_COLOR.
//   - top_flag = (sel == N_LAYERS-1).
//   - blank = hblnk_in | vblnk_in.
//  Stage 2 (registered)
//   - blank           -> rgb_out = 0, regardless of mode.
//   - 00 normal       -> pixel.
//   - 01 dim          -> each channel >>1 (logical), except pixels from the top layer (top_flag), which pass unchanged.
//   - 10 flash        -> phase 0: pixel; phase 1: bitwise-inverted pixel (all RGB_W bits).
//   - 11 black        -> 0.
//  Latency
//   - Fixed 2 cycles from inputs to every output.
//   - Timing outputs are delayed exactly 2 cycles, so rgb_out stays aligned with hcount_out/vcount_out.
//  Boundaries
//   - Simultaneous opaque layers: highest index wins.
//   - Enabled layers with none opaque: BG_COLOR.
//   - Disabled opaque layers are ignored.
//   - vsync held high for many cycles: exactly one load and one pulse.
//   - FLASH_FRAMES=1: phase toggles every frame.
// TESTING
//  T1 reset: assert rst mid-line with layers active -> all outputs 0 while held. After release, rgb_out = BG_COLOR until first frame_start.
//  T2 priority: en=7'h7F; opaque on layers 0,3,5 with colours 12'h111/333/555 -> rgb_out = 12'h555 two cycles later. Drop layer 5 opaque -> 12'h333.
//  T3 frame sync: change layer_en_in 7'h01->7'h00 mid-frame -> output unchanged until the vsync rise. The 1-cycle frame_start pulse follows it; then output = BG_COLOR.
//  T4 dim: mode 01, layer 2 = 12'hF8A -> rgb_out = 12'h745. Layer 6 = 12'hF8A -> rgb_out = 12'hF8A.
//  T5 flash: mode 10, FLASH_FRAMES=2, pixel 12'h0F0 -> frames 0-1 give 12'h0F0, frames 2-3 give 12'hF0F, then repeat.
//  T6 blank/latency: hblnk_in=1 in mode 10 phase 1 -> rgb_out = 0. A pulse on hsync_in appears on hsync_out exactly 2 cycles later.

Source files
------------

// File: rtl/vga_layer_compositor_if.sv
// Bundle of timing, layer and composited-output signals for vga_layer_compositor.
// master: timing generator / layer sources side (drives *_in, observes *_out).
// slave : the compositor (consumes *_in, drives *_out).
//   hcount/vcount     11-bit pixel/line counters
//   hsync/vsync       sync strobes
//   hblnk/vblnk       blanking strobes
//   layer_rgb_in      layer i colour at bits [i*RGB_W +: RGB_W]
//   layer_opaque_in   per-layer "draws this pixel"
//   layer_en_in       requested layer enables (taken at the next vsync rise)
//   mode_in           00 normal, 01 dim, 10 flash, 11 black
//   rgb_out           composited pixel, aligned with the *_out timing
//   frame_start       1-cycle pulse after each vsync rise
interface vga_layer_compositor_if #(
    parameter int unsigned N_LAYERS = 7,
    parameter int unsigned RGB_W    = 12
);
    logic [10:0]               hcount_in;
    logic [10:0]               vcount_in;
    logic                      hsync_in;
    logic                      vsync_in;
    logic                      hblnk_in;
    logic                      vblnk_in;
    logic [N_LAYERS*RGB_W-1:0] layer_rgb_in;
    logic [N_LAYERS-1:0]       layer_opaque_in;
    logic [N_LAYERS-1:0]       layer_en_in;
    logic [1:0]                mode_in;

    logic [10:0]               hcount_out;
    logic [10:0]               vcount_out;
    logic                      hsync_out;
    logic                      vsync_out;
    logic                      hblnk_out;
    logic                      vblnk_out;
    logic [RGB_W-1:0]          rgb_out;
    logic                      frame_start;

    modport master (
        output hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in,
        output layer_rgb_in, layer_opaque_in, layer_en_in, mode_in,
        input  hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
        input  rgb_out, frame_start
    );

    modport slave (
        input  hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in,
        input  layer_rgb_in, layer_opaque_in, layer_en_in, mode_in,
        output hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
        output rgb_out, frame_start
    );
endinterface

// File: rtl/vga_layer_compositor.sv
// N-layer pixel compositor with a 2-stage pipeline.
// Stage 1 picks the highest-index enabled opaque layer (or BG_COLOR); stage 2 applies the
// display mode and blanking. Layer enables and mode are shadowed on each vsync rise so a
// frame is always drawn with one consistent configuration.
// Ports:
//   clk  pixel clock
//   rst  asynchronous active-high reset
//   bus  vga_layer_compositor_if.slave (timing in/out, layer data, mode, rgb_out, frame_start)
module vga_layer_compositor #(
    parameter int unsigned      N_LAYERS     = 7,
    parameter int unsigned      RGB_W        = 12,
    parameter logic [RGB_W-1:0] BG_COLOR     = '0,
    parameter int unsigned      FLASH_FRAMES = 30
) (
    input logic                    clk,
    input logic                    rst,
    vga_layer_compositor_if.slave  bus
);

    localparam int unsigned      CH_W    = RGB_W / 3;
    localparam int unsigned      CNT_W   = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FLASH_FRAMES - 1);

    // Frame-synchronous state
    logic                r_vsync_prev;
    logic [N_LAYERS-1:0] r_shadow_en;
    logic [1:0]          r_shadow_mode;
    logic [CNT_W-1:0]    r_frame_cnt;
    logic                r_flash_phase;
    logic                r_frame_start;

    // Stage 1
    logic [10:0]      r_s1_hcount, r_s1_vcount;
    logic             r_s1_hsync, r_s1_vsync, r_s1_hblnk, r_s1_vblnk;
    logic [RGB_W-1:0] r_s1_pix;
    logic             r_s1_top, r_s1_blank, r_s1_phase;
    logic [1:0]       r_s1_mode;

    // Stage 2
    logic [10:0]      r_s2_hcount, r_s2_vcount;
    logic             r_s2_hsync, r_s2_vsync, r_s2_hblnk, r_s2_vblnk;
    logic [RGB_W-1:0] r_s2_rgb;

    logic                w_vs_rise;
    logic [N_LAYERS-1:0] w_masked;
    logic [RGB_W-1:0]    w_pix;
    logic [RGB_W-1:0]    w_dim;
    logic [RGB_W-1:0]    w_rgb_nxt;

    assign w_vs_rise = bus.vsync_in & ~r_vsync_prev;
    assign w_masked  = r_shadow_en & bus.layer_opaque_in;

    // Ascending scan so the highest set index is the last to write w_pix.
    always_comb begin
        w_pix = BG_COLOR;
        for (int i = 0; i < N_LAYERS; i++) begin
            if (w_masked[i]) w_pix = bus.layer_rgb_in[i*RGB_W +: RGB_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vsync_prev  <= 1'b0;
            r_shadow_en   <= '0;
            r_shadow_mode <= 2'b00;
            r_frame_cnt   <= '0;
            r_flash_phase <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_vsync_prev  <= bus.vsync_in;
            r_frame_start <= w_vs_rise;
            if (w_vs_rise) begin
                r_shadow_en   <= bus.layer_en_in;
                r_shadow_mode <= bus.mode_in;
                if (r_frame_cnt == CNT_MAX) begin
                    r_frame_cnt   <= '0;
                    r_flash_phase <= ~r_flash_phase;
                end else begin
                    r_frame_cnt <= r_frame_cnt + 1'b1;
                end
            end
        end
    end

    // Mode and phase travel with the pixel so a shadow update cannot split a pixel's
    // selection (stage 1) from its treatment (stage 2).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_hcount <= '0;
            r_s1_vcount <= '0;
            r_s1_hsync  <= 1'b0;
            r_s1_vsync  <= 1'b0;
            r_s1_hblnk  <= 1'b0;
            r_s1_vblnk  <= 1'b0;
            r_s1_pix    <= '0;
            r_s1_top    <= 1'b0;
            r_s1_blank  <= 1'b0;
            r_s1_mode   <= 2'b00;
            r_s1_phase  <= 1'b0;
        end else begin
            r_s1_hcount <= bus.hcount_in;
            r_s1_vcount <= bus.vcount_in;
            r_s1_hsync  <= bus.hsync_in;
            r_s1_vsync  <= bus.vsync_in;
            r_s1_hblnk  <= bus.hblnk_in;
            r_s1_vblnk  <= bus.vblnk_in;
            r_s1_pix    <= w_pix;
            r_s1_top    <= w_masked[N_LAYERS-1];
            r_s1_blank  <= bus.hblnk_in | bus.vblnk_in;
            r_s1_mode   <= r_shadow_mode;
            r_s1_phase  <= r_flash_phase;
        end
    end

    always_comb begin
        w_dim = '0;
        for (int c = 0; c < 3; c++) begin
            w_dim[c*CH_W +: CH_W] = r_s1_pix[c*CH_W +: CH_W] >> 1;
        end
    end

    always_comb begin
        w_rgb_nxt = r_s1_pix;
        if (r_s1_blank) begin
            w_rgb_nxt = '0;
        end else begin
            case (r_s1_mode)
                2'b00:   w_rgb_nxt = r_s1_pix;
                2'b01:   w_rgb_nxt = r_s1_top ? r_s1_pix : w_dim;
                2'b10:   w_rgb_nxt = r_s1_phase ? ~r_s1_pix : r_s1_pix;
                default: w_rgb_nxt = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_hcount <= '0;
            r_s2_vcount <= '0;
            r_s2_hsync  <= 1'b0;
            r_s2_vsync  <= 1'b0;
            r_s2_hblnk  <= 1'b0;
            r_s2_vblnk  <= 1'b0;
            r_s2_rgb    <= '0;
        end else begin
            r_s2_hcount <= r_s1_hcount;
            r_s2_vcount <= r_s1_vcount;
            r_s2_hsync  <= r_s1_hsync;
            r_s2_vsync  <= r_s1_vsync;
            r_s2_hblnk  <= r_s1_hblnk;
            r_s2_vblnk  <= r_s1_vblnk;
            r_s2_rgb    <= w_rgb_nxt;
        end
    end

    assign bus.hcount_out  = r_s2_hcount;
    assign bus.vcount_out  = r_s2_vcount;
    assign bus.hsync_out   = r_s2_hsync;
    assign bus.vsync_out   = r_s2_vsync;
    assign bus.hblnk_out   = r_s2_hblnk;
    assign bus.vblnk_out   = r_s2_vblnk;
    assign bus.rgb_out     = r_s2_rgb;
    assign bus.frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_layer_compositor.sv
// Self-checking bench for vga_layer_compositor (7 layers, 12-bit RGB, BG 12'h123,
// FLASH_FRAMES=2). A frame-level model predicts every output each cycle; directed
// scenarios add hand-computed pixel values that pin both the DUT and the model.
module tb_vga_layer_compositor;

    localparam int unsigned NL = 7;
    localparam int unsigned FF = 2;
    localparam logic [11:0] BG = 12'h123;

    logic clk = 1'b0;
    logic rst = 1'b1;

    vga_layer_compositor_if #(.N_LAYERS(NL), .RGB_W(12)) bus ();

    vga_layer_compositor #(
        .N_LAYERS    (NL),
        .RGB_W       (12),
        .BG_COLOR    (BG),
        .FLASH_FRAMES(FF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Model state: configuration as of the last vsync rise and number of rises since reset
    logic [NL-1:0] m_en;
    logic [1:0]    m_mode;
    int            m_rises;
    logic          m_prev_vs;
    // Expected outputs for the pixel currently in the DUT's second stage
    logic [10:0]   e_hc, e_vc;
    logic          e_hs, e_vs, e_hb, e_vb;
    logic [11:0]   e_rgb;
    logic [11:0]   m_last_rgb;

    function automatic logic [11:0] model_rgb(input logic [NL-1:0] en, input logic [1:0] mode,
                                              input int rises);
        logic [11:0] pix;
        logic        top;
        logic        found;
        int          r, g, b;
        pix = BG;
        top = 1'b0;
        found = 1'b0;
        for (int i = NL - 1; i >= 0; i--) begin
            if (!found && en[i] && bus.layer_opaque_in[i]) begin
                pix   = bus.layer_rgb_in[i*12 +: 12];
                found = 1'b1;
                top   = (i == NL - 1);
            end
        end
        if (bus.hblnk_in || bus.vblnk_in) return 12'h000;
        case (mode)
            2'd0: return pix;
            2'd1: begin
                if (top) return pix;
                r = pix[11:8] / 2;
                g = pix[7:4] / 2;
                b = pix[3:0] / 2;
                return 12'(r * 256 + g * 16 + b);
            end
            2'd2: return (((rises / FF) % 2) == 1) ? 12'hFFF - pix : pix;
            default: return 12'h000;
        endcase
    endfunction

    // Inputs change at negedge+1, so at each negedge the applied inputs are the ones the
    // preceding posedge captured; their result appears at the next negedge.
    always @(negedge clk) begin
        logic rise;
        cyc++;
        n_vec++;
        if (rst) begin
            if ({bus.hcount_out, bus.vcount_out, bus.hsync_out, bus.vsync_out, bus.hblnk_out,
                 bus.vblnk_out, bus.rgb_out, bus.frame_start} !== '0) begin
                n_err++;
                $display("FAIL reset_outputs cyc %0d: hc=%h vc=%h sync=%b%b blnk=%b%b rgb=%h fs=%b, required all 0",
                         cyc, bus.hcount_out, bus.vcount_out, bus.hsync_out, bus.vsync_out,
                         bus.hblnk_out, bus.vblnk_out, bus.rgb_out, bus.frame_start);
            end
            m_last_rgb = 12'h000;
            {e_hc, e_vc, e_hs, e_vs, e_hb, e_vb, e_rgb} = '0;
            m_en = '0;
            m_mode = 2'd0;
            m_rises = 0;
            m_prev_vs = 1'b0;
        end else begin
            rise = bus.vsync_in && !m_prev_vs;
            if (bus.hcount_out !== e_hc || bus.vcount_out !== e_vc || bus.hsync_out !== e_hs ||
                bus.vsync_out !== e_vs || bus.hblnk_out !== e_hb || bus.vblnk_out !== e_vb ||
                bus.rgb_out !== e_rgb || bus.frame_start !== rise) begin
                n_err++;
                $display("FAIL cycle_outputs cyc %0d: got hc=%h vc=%h s=%b%b b=%b%b rgb=%h fs=%b, required hc=%h vc=%h s=%b%b b=%b%b rgb=%h fs=%b",
                         cyc, bus.hcount_out, bus.vcount_out, bus.hsync_out, bus.vsync_out,
                         bus.hblnk_out, bus.vblnk_out, bus.rgb_out, bus.frame_start,
                         e_hc, e_vc, e_hs, e_vs, e_hb, e_vb, e_rgb, rise);
            end
            m_last_rgb = e_rgb;
            e_hc  = bus.hcount_in;
            e_vc  = bus.vcount_in;
            e_hs  = bus.hsync_in;
            e_vs  = bus.vsync_in;
            e_hb  = bus.hblnk_in;
            e_vb  = bus.vblnk_in;
            e_rgb = model_rgb(m_en, m_mode, m_rises);
            if (rise) begin
                m_en = bus.layer_en_in;
                m_mode = bus.mode_in;
                m_rises++;
            end
            m_prev_vs = bus.vsync_in;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
            bus.hcount_in = bus.hcount_in + 11'd1;
        end
    endtask

    task automatic pin_rgb(input string name, input logic [11:0] exp);
        n_vec++;
        if (bus.rgb_out !== exp) begin
            n_err++;
            $display("FAIL %s: rgb_out=%h required %h", name, bus.rgb_out, exp);
        end
        n_vec++;
        if (m_last_rgb !== exp) begin
            n_err++;
            $display("FAIL %s_model: model rgb=%h required %h", name, m_last_rgb, exp);
        end
    endtask

    task automatic pin_bit(input string name, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b required %b", name, got, exp);
        end
    endtask

    task automatic set_layer(input int i, input logic [11:0] c);
        bus.layer_rgb_in[i*12 +: 12] = c;
    endtask

    // One short frame: vsync high for a cycle, then enough cycles to flush the pipeline.
    task automatic frame();
        bus.vcount_in = bus.vcount_in + 11'd1;
        bus.vsync_in = 1'b1;
        step(1);
        bus.vsync_in = 1'b0;
        step(3);
    endtask

    initial begin
        bus.hcount_in = '0;
        bus.vcount_in = '0;
        bus.hsync_in = 1'b0;
        bus.vsync_in = 1'b0;
        bus.hblnk_in = 1'b0;
        bus.vblnk_in = 1'b0;
        bus.layer_rgb_in = '0;
        bus.layer_opaque_in = '0;
        bus.layer_en_in = '0;
        bus.mode_in = 2'd0;
        step(3);

        // T1/T2 setup: release reset with layers active, nothing shadowed yet
        rst = 1'b0;
        set_layer(0, 12'h111);
        set_layer(3, 12'h333);
        set_layer(5, 12'h555);
        bus.layer_opaque_in = 7'b0101001;
        bus.layer_en_in = 7'h7F;
        step(3);
        pin_rgb("bg_after_reset", BG);

        // vsync held high: one load, one pulse
        bus.vsync_in = 1'b1;
        step(1);
        pin_bit("frame_start_pulse", bus.frame_start, 1'b1);
        step(1);
        pin_bit("frame_start_single", bus.frame_start, 1'b0);
        step(4);
        bus.vsync_in = 1'b0;
        step(2);

        // T2 priority
        pin_rgb("prio_layer5", 12'h555);
        bus.layer_opaque_in = 7'b0001001;
        step(2);
        pin_rgb("prio_layer3", 12'h333);
        bus.layer_opaque_in = 7'b0000000;
        step(2);
        pin_rgb("none_opaque_bg", BG);

        // T1 reset mid-line
        bus.layer_opaque_in = 7'b0101001;
        bus.hblnk_in = 1'b0;
        rst = 1'b1;
        step(2);
        pin_rgb("reset_held", 12'h000);
        rst = 1'b0;
        step(2);
        pin_rgb("reset_release_bg", BG);

        // T3 frame sync
        bus.layer_en_in = 7'h01;
        bus.layer_opaque_in = 7'b0000001;
        frame();
        pin_rgb("sync_en01", 12'h111);
        bus.layer_en_in = 7'h00;
        step(3);
        pin_rgb("sync_midframe_hold", 12'h111);
        bus.vsync_in = 1'b1;
        step(1);
        pin_bit("sync_frame_start", bus.frame_start, 1'b1);
        bus.vsync_in = 1'b0;
        step(1);
        pin_bit("sync_frame_start_end", bus.frame_start, 1'b0);
        pin_rgb("sync_old_cfg_last", 12'h111);
        step(1);
        pin_rgb("sync_new_cfg_bg", BG);

        // T4 dim
        bus.mode_in = 2'b01;
        bus.layer_en_in = 7'h7F;
        set_layer(2, 12'hF8A);
        bus.layer_opaque_in = 7'b0000100;
        frame();
        pin_rgb("dim_layer2", 12'h745);
        set_layer(6, 12'hF8A);
        bus.layer_opaque_in = 7'b1000100;
        step(2);
        pin_rgb("dim_top_layer", 12'hF8A);
        bus.layer_en_in = 7'h3F;
        frame();
        pin_rgb("disabled_top_ignored", 12'h745);

        // T5 flash from a clean counter
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        bus.mode_in = 2'b10;
        bus.layer_en_in = 7'h7F;
        set_layer(1, 12'h0F0);
        bus.layer_opaque_in = 7'b0000010;
        step(3);
        pin_rgb("flash_frame0_bg", BG);
        frame();
        pin_rgb("flash_frame1", 12'h0F0);
        frame();
        pin_rgb("flash_frame2", 12'hF0F);

        // T6 blanking in phase 1, sync latency
        bus.hblnk_in = 1'b1;
        step(2);
        pin_rgb("blank_phase1", 12'h000);
        bus.hblnk_in = 1'b0;
        bus.vblnk_in = 1'b1;
        step(2);
        pin_rgb("vblank_phase1", 12'h000);
        bus.vblnk_in = 1'b0;
        bus.hsync_in = 1'b1;
        step(1);
        bus.hsync_in = 1'b0;
        pin_bit("hsync_lat1", bus.hsync_out, 1'b0);
        step(1);
        pin_bit("hsync_lat2", bus.hsync_out, 1'b1);
        step(1);
        pin_bit("hsync_lat3", bus.hsync_out, 1'b0);

        frame();
        pin_rgb("flash_frame3", 12'hF0F);
        frame();
        pin_rgb("flash_frame4", 12'h0F0);

        // Black mode
        bus.mode_in = 2'b11;
        frame();
        pin_rgb("black_mode", 12'h000);
        step(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
